op_modulation_router: RTL
=========================

# op_modulation_router

Per-operator modulation source for the OPL3 operator pipeline. It sits on the return path of the operator datapath: it captures each operator's signed output `out_p6` as it leaves the phase generator and stores it in per-bank/per-operator history. When the sequencer issues the next operator slot, it returns the matching phase modulation word `modulation_p1`, which is either self-feedback, the FM modulator's output, or zero.

## Interface
Parameters (shared package constants, no local overrides):
- NUM_BANKS, 2, number of register banks.
- NUM_OPERATORS_PER_BANK, 18, operator slots per bank.
- OP_OUT_WIDTH, 13, signed operator output width.

Ports:
- clk  in  1  system clock; all state on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- sample_clk_en  in  1  slot-issue strobe (p0); qualifies all p0 inputs.
- bank_num  in  BANK_NUM_WIDTH  bank of the requesting slot (p0).
- op_num  in  OP_NUM_WIDTH  operator of the requesting slot (p0).
- mod_role  in  $bits(mod_role_t)  MOD_NONE / MOD_FEEDBACK / MOD_FM (p0).
- mod_src_op  in  OP_NUM_WIDTH  modulator operator in the same bank, used for MOD_FM (p0).
- fb  in  REG_FB_WIDTH (3)  feedback level, used for MOD_FEEDBACK (p0).
- out_p6  in  OP_OUT_WIDTH signed  operator output, 6 cycles after its slot's p0.
- modulation_p1  out  OP_OUT_WIDTH signed  modulation for the slot issued one cycle earlier. Reset value 0.

## Operation
- Internal 6-deep shift registers carry sample_clk_en, bank_num and op_num from p0 to p6. The write qualifier is sample_clk_en_p[6]; write address is {bank_num_p[6], op_num_p[6]}.
- History storage: register arrays hist1 and hist2, each [NUM_BANKS][NUM_OPERATORS_PER_BANK] × OP_OUT_WIDTH.
  - All entries reset to 0 asynchronously.
  - Not RAM, because a reset clear is required.
- Write at p6: hist2[a] <= hist1[a]; hist1[a] <= out_p6. Every slot writes, whatever its role.
- Read and compute at p0, when sample_clk_en = 1:
  - MOD_NONE: 0.
  - MOD_FEEDBACK, fb = 0: 0.
  - MOD_FEEDBACK, fb ≠ 0: (sext14(h1) + sext14(h2)) >>> (9 − fb), truncated to OP_OUT_WIDTH. The arithmetic shift floors toward −∞. Worst case fb = 7 gives ±8192 >>> 2 = ±2048, so there is no overflow.
  - MOD_FM: h1 of {bank_num, mod_src_op}.
  - Undefined mod_role encoding: 0.
- Write/read forwarding: if a p6 write and a p0 read hit the same address in the same cycle:
  - h1 = out_p6 (the incoming value).
  - h2 = old hist1.
- With sample_clk_en = 0, modulation_p1 holds its value and no history is read.
- No key-on clearing of history: it persists across notes, matching chip behaviour.

## Timing
- Latency: p0 request → modulation_p1 registered and valid on the next edge (p1). The phase generator consumes it at its p1.
- Write path: history is updated on the edge that ends cycle p6. It is visible to a p0 read in the same cycle through forwarding, and to later reads from the array.
- Back-to-back slots every cycle are supported; there are no stalls and no handshake.
- Reset mid-operation, as long as reset_n is low:
  - all history, pipeline valids and modulation_p1 are 0;
  - in-flight p1..p6 writes are discarded.
- Release: the first request after reset_n rises returns 0 for every role.
- A write and a read to different addresses in the same cycle are independent.
- sample_clk_en_p[6] = 0 with a garbage out_p6 causes no write.

## Structure
- opl3_pkg gains:
  - typedef enum mod_role_t {MOD_NONE, MOD_FEEDBACK, MOD_FM};
  - REG_FB_WIDTH = 3.
  - The existing BANK_NUM_WIDTH, OP_NUM_WIDTH, OP_OUT_WIDTH, NUM_BANKS and NUM_OPERATORS_PER_BANK are reused.
- Sub-modules:
  - Reuse pipeline_sr for the p1..p6 delay lines.
  - One new sub-module, op_history_regfile: the dual-entry register file with async clear, a 1-write/2-read port and same-address forwarding.
  - The modulation arithmetic stays in the top module.

## Test plan
- Reset: hold reset_n low for 3 cycles mid-stream with sample_clk_en toggling → modulation_p1 = 0 throughout. The first post-reset MOD_FM and MOD_FEEDBACK (fb = 7) requests return 0.
- Feedback math:
  - Write 1000 then 600 to bank0/op0, then request MOD_FEEDBACK fb = 7 → (600 + 1000) >>> 2 = 400.
  - Same history with fb = 1 → 1600 >>> 8 = 6.
  - fb = 0 → 0.
- Negative floor: history −3, −2, request fb = 7 → −5 >>> 2 = −2, not −1.
- FM routing: write −1234 to bank1/op3, then request bank1/op6 with MOD_FM and mod_src_op = 3 → −1234 one cycle later. The same request from bank0 returns bank0/op3's value.
- Forwarding: issue bank0/op0 at cycle t and again at t+6 (its p6 write coincides with the new p0) with out_p6 = 500 and prior hist1 = 200, fb = 7 → (500 + 200) >>> 2 = 175.
- Idle hold: drop sample_clk_en for 10 cycles after a request returning 175 → modulation_p1 stays 175. A p6 slot with its valid deasserted leaves the history unchanged.

Source files
------------

// File: rtl/opl3_pkg.sv
// opl3_pkg: shared OPL3 widths, counts and operator modulation role encoding
package opl3_pkg;
  localparam int NUM_BANKS = 2;
  localparam int NUM_OPERATORS_PER_BANK = 18;
  localparam int OP_OUT_WIDTH = 13;
  localparam int BANK_NUM_WIDTH = $clog2(NUM_BANKS);
  localparam int OP_NUM_WIDTH = $clog2(NUM_OPERATORS_PER_BANK);
  localparam int REG_FB_WIDTH = 3;
  typedef enum logic [1:0] {MOD_NONE, MOD_FEEDBACK, MOD_FM} mod_role_t;
endpackage

// File: rtl/op_history_regfile.sv
// op_history_regfile: two-deep per-operator output history, 1 write / 2 read with same-address forwarding
module op_history_regfile
  import opl3_pkg::*;
(
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           i_wr_en,
  input  logic [BANK_NUM_WIDTH-1:0]      i_wr_bank,
  input  logic [OP_NUM_WIDTH-1:0]        i_wr_op,
  input  logic signed [OP_OUT_WIDTH-1:0] i_wr_data,
  input  logic [BANK_NUM_WIDTH-1:0]      i_rd_bank,
  input  logic [OP_NUM_WIDTH-1:0]        i_rd_op_a,
  input  logic [OP_NUM_WIDTH-1:0]        i_rd_op_b,
  output logic signed [OP_OUT_WIDTH-1:0] o_a_h1,
  output logic signed [OP_OUT_WIDTH-1:0] o_a_h2,
  output logic signed [OP_OUT_WIDTH-1:0] o_b_h1
);
  localparam logic [OP_NUM_WIDTH-1:0] OP_CNT = OP_NUM_WIDTH'(NUM_OPERATORS_PER_BANK);
  logic signed [OP_OUT_WIDTH-1:0] r_hist1 [NUM_BANKS][NUM_OPERATORS_PER_BANK];
  logic signed [OP_OUT_WIDTH-1:0] r_hist2 [NUM_BANKS][NUM_OPERATORS_PER_BANK];
  logic w_wr, w_hit_a, w_hit_b, w_ok_a, w_ok_b;
  assign w_wr = i_wr_en && (i_wr_op < OP_CNT);
  assign w_ok_a = i_rd_op_a < OP_CNT;
  assign w_ok_b = i_rd_op_b < OP_CNT;
  assign w_hit_a = w_wr && (i_wr_bank == i_rd_bank) && (i_wr_op == i_rd_op_a);
  assign w_hit_b = w_wr && (i_wr_bank == i_rd_bank) && (i_wr_op == i_rd_op_b);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int b = 0; b < NUM_BANKS; b++)
        for (int o = 0; o < NUM_OPERATORS_PER_BANK; o++) begin
          r_hist1[b][o] <= '0;
          r_hist2[b][o] <= '0;
        end
    end else if (w_wr) begin
      r_hist2[i_wr_bank][i_wr_op] <= r_hist1[i_wr_bank][i_wr_op];
      r_hist1[i_wr_bank][i_wr_op] <= i_wr_data;
    end
  end
  // a same-cycle write shifts history, so h2 sees the value hist1 is about to lose
  assign o_a_h1 = w_hit_a ? i_wr_data : w_ok_a ? r_hist1[i_rd_bank][i_rd_op_a] : '0;
  assign o_a_h2 = !w_ok_a ? '0 : w_hit_a ? r_hist1[i_rd_bank][i_rd_op_a] : r_hist2[i_rd_bank][i_rd_op_a];
  assign o_b_h1 = w_hit_b ? i_wr_data : w_ok_b ? r_hist1[i_rd_bank][i_rd_op_b] : '0;
endmodule

// File: rtl/pipeline_sr.sv
// pipeline_sr: fixed-depth delay line with asynchronous clear
module pipeline_sr #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);
  logic [WIDTH-1:0] r_sr [DEPTH];
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) r_sr[i] <= '0;
    end else begin
      r_sr[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) r_sr[i] <= r_sr[i-1];
    end
  end
  assign o_q = r_sr[DEPTH-1];
endmodule

// File: rtl/op_modulation_router.sv
// op_modulation_router: per-operator phase modulation (self-feedback / FM / none) from output history
module op_modulation_router
  import opl3_pkg::*;
(
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           sample_clk_en,
  input  logic [BANK_NUM_WIDTH-1:0]      bank_num,
  input  logic [OP_NUM_WIDTH-1:0]        op_num,
  input  logic [$bits(mod_role_t)-1:0]   mod_role,
  input  logic [OP_NUM_WIDTH-1:0]        mod_src_op,
  input  logic [REG_FB_WIDTH-1:0]        fb,
  input  logic signed [OP_OUT_WIDTH-1:0] out_p6,
  output logic signed [OP_OUT_WIDTH-1:0] modulation_p1
);
  localparam int PW = 1 + BANK_NUM_WIDTH + OP_NUM_WIDTH;
  logic [PW-1:0] w_p6;
  logic signed [OP_OUT_WIDTH-1:0] w_h1, w_h2, w_fm, w_fb_mod, w_mod;
  logic signed [OP_OUT_WIDTH:0] w_sum;
  logic [3:0] w_sh;
  logic signed [OP_OUT_WIDTH-1:0] r_mod;
  pipeline_sr #(.WIDTH(PW), .DEPTH(6)) u_sr (
    .clk     (clk),
    .reset_n (reset_n),
    .i_d     ({sample_clk_en, bank_num, op_num}),
    .o_q     (w_p6)
  );
  op_history_regfile u_hist (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_wr_en   (w_p6[PW-1]),
    .i_wr_bank (w_p6[PW-2 -: BANK_NUM_WIDTH]),
    .i_wr_op   (w_p6[OP_NUM_WIDTH-1:0]),
    .i_wr_data (out_p6),
    .i_rd_bank (bank_num),
    .i_rd_op_a (op_num),
    .i_rd_op_b (mod_src_op),
    .o_a_h1    (w_h1),
    .o_a_h2    (w_h2),
    .o_b_h1    (w_fm)
  );
  // 14-bit sum cannot overflow; shift of at least 2 brings it back into 13 bits
  assign w_sum = {w_h1[OP_OUT_WIDTH-1], w_h1} + {w_h2[OP_OUT_WIDTH-1], w_h2};
  assign w_sh = 4'd9 - {1'b0, fb};
  assign w_fb_mod = OP_OUT_WIDTH'(w_sum >>> w_sh);
  always_comb begin
    w_mod = (mod_role == MOD_FEEDBACK && fb != '0) ? w_fb_mod : (mod_role == MOD_FM) ? w_fm : '0;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_mod <= '0;
    else if (sample_clk_en) r_mod <= w_mod;
  end
  assign modulation_p1 = r_mod;
endmodule
